// File: rtl/timer_bank_pkg.sv
// Shared definitions for the multi-channel countdown timer bank.
// Command encodings, default widths and the per-channel state type.
package timer_bank_pkg;

    localparam int W_DEF = 16;
    localparam int N_DEF = 4;
    localparam int S_DEF = 2;
    localparam int P_DEF = 8;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_START = 2'b11;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'b00,
        CH_RUN    = 2'b01,
        CH_PAUSED = 2'b10
    } ch_state_e;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: count, reload, mode, run state and expiry flop.
// Commands for this channel override a coincident prescaler tick.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick,
    input  logic         load,
    input  logic         stop,
    input  logic         start,
    input  logic [W-1:0] value,
    input  logic         periodic,
    output logic [W-1:0] count,
    output logic         active,
    output logic         expire
);

    ch_state_e    state;
    logic [W-1:0] reload;
    logic         mode;
    logic         run_tick;

    assign active   = (state == CH_RUN);
    assign run_tick = tick && (state == CH_RUN) && !(load || stop || start);

    // Channel state, count and one-clock expiry pulse
    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= CH_IDLE;
            count  <= '0;
            reload <= '0;
            mode   <= 1'b0;
            expire <= 1'b0;
        end else begin
            expire <= 1'b0;
            unique case (1'b1)
                load: begin
                    reload <= value;
                    count  <= value;
                    mode   <= periodic;
                    state  <= (value != '0) ? CH_RUN : CH_IDLE;
                end
                stop: begin
                    if (state == CH_RUN) state <= CH_PAUSED;
                end
                start: begin
                    if (count != '0) state <= CH_RUN;
                end
                run_tick: begin
                    if (count > W'(1)) begin
                        count <= count - W'(1);
                    end else if (count == W'(1)) begin
                        expire <= 1'b1;
                        if (mode && reload != '0) begin
                            count <= reload;
                        end else begin
                            count <= '0;
                            state <= CH_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/timer_bank.sv
// N-channel countdown timer bank with a shared tick prescaler.
// Software addresses one channel per clock through sel/cmd.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF,
    parameter int S = S_DEF,
    parameter int P = P_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [P-1:0] div,
    input  logic [S-1:0] sel,
    input  logic [1:0]   cmd,
    input  logic [W-1:0] value,
    input  logic         periodic,
    output logic [W-1:0] rdata,
    output logic [N-1:0] active,
    output logic [N-1:0] expire
);

    logic [P-1:0] pre;
    logic         tick;
    logic [N-1:0] load;
    logic [N-1:0] stop;
    logic [N-1:0] start;
    logic [W-1:0] count [N];
    logic [W-1:0] rd_next;

    assign tick = (pre == '0);

    // Prescaler: a new divisor is picked up only when pre reloads
    always_ff @(posedge clock) begin
        if (!reset) begin
            pre <= '0;
        end else if (tick) begin
            pre <= div;
        end else begin
            pre <= pre - P'(1);
        end
    end

    // Command decode; out-of-range sel matches no channel
    always_comb begin
        load  = '0;
        stop  = '0;
        start = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(sel) == i) begin
                load[i]  = (cmd == CMD_LOAD);
                stop[i]  = (cmd == CMD_STOP);
                start[i] = (cmd == CMD_START);
            end
        end
    end

    // Read mux; out-of-range sel reads zero
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(sel) == i) rd_next = count[i];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        timer_channel #(
            .W(W)
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .tick    (tick),
            .load    (load[i]),
            .stop    (stop[i]),
            .start   (start[i]),
            .value   (value),
            .periodic(periodic),
            .count   (count[i]),
            .active  (active[i]),
            .expire  (expire[i])
        );
    end

    // Registered readback of the pre-update count
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata <= '0;
        end else begin
            rdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank.
// A second 3-channel instance covers out-of-range channel select.
module tb_timer_bank;

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] LOAD  = 2'b01;
    localparam logic [1:0] STOP  = 2'b10;
    localparam logic [1:0] START = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  div = '0;
    logic [1:0]  sel = '0;
    logic [1:0]  cmd = NOP;
    logic [15:0] value = '0;
    logic        periodic = 1'b0;
    logic [15:0] rdata;
    logic [3:0]  active;
    logic [3:0]  expire;
    logic [15:0] rdata3;
    logic [2:0]  active3;
    logic [2:0]  expire3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    timer_bank #(.W(16), .N(4), .S(2), .P(8)) u_dut (
        .clock   (clock),
        .reset   (reset),
        .div     (div),
        .sel     (sel),
        .cmd     (cmd),
        .value   (value),
        .periodic(periodic),
        .rdata   (rdata),
        .active  (active),
        .expire  (expire)
    );

    timer_bank #(.W(16), .N(3), .S(2), .P(8)) u_dut3 (
        .clock   (clock),
        .reset   (reset),
        .div     (div),
        .sel     (sel),
        .cmd     (cmd),
        .value   (value),
        .periodic(periodic),
        .rdata   (rdata3),
        .active  (active3),
        .expire  (expire3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] s, input logic [1:0] c,
                         input logic [15:0] v, input logic p);
        sel = s;
        cmd = c;
        value = v;
        periodic = p;
        clk1();
        cmd = NOP;
    endtask

    task automatic do_reset();
        cmd = NOP;
        div = 8'd0;
        reset = 1'b0;
        clk1();
        reset = 1'b1;
    endtask

    logic [3:0] exp_ind [10];

    initial begin
        exp_ind = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0,
                    4'h4, 4'h0, 4'h8, 4'h0, 4'h0};

        // Power-on reset state
        clk1();
        clk1();
        check("rst_rdata", rdata, 0);
        check("rst_active", active, 0);
        check("rst_expire", expire, 0);
        reset = 1'b1;

        // Random traffic, then reset mid-countdown
        for (int i = 0; i < 30; i++) begin
            div = 8'($urandom_range(0, 3));
            sel = 2'($urandom_range(0, 3));
            cmd = 2'($urandom_range(0, 3));
            value = 16'($urandom_range(0, 20));
            periodic = 1'($urandom_range(0, 1));
            clk1();
        end
        cmd = NOP;
        div = 8'd0;
        issue(2'd0, LOAD, 16'd100, 1'b1);
        clk1();
        clk1();
        clk1();
        check("mid_active_pre", active[0], 1);
        reset = 1'b0;
        clk1();
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_active", active, 0);
        check("mid_rst_expire", expire, 0);
        check("mid_rst_active3", active3, 0);
        reset = 1'b1;
        sel = 2'd0;
        for (int k = 0; k < 20; k++) begin
            clk1();
            check("post_rst_expire", expire, 0);
            check("post_rst_rdata", rdata, 0);
        end

        // One-shot, div=0
        do_reset();
        issue(2'd0, LOAD, 16'd3, 1'b0);
        check("os_active_on", active[0], 1);
        check("os_expire_0", expire[0], 0);
        for (int k = 1; k <= 4; k++) begin
            clk1();
            check("os_rdata", rdata, 32'(4 - k));
            check("os_expire", expire[0], (k == 3) ? 1 : 0);
        end
        check("os_active_off", active[0], 0);

        // Periodic with prescaler div=3, reload 2
        do_reset();
        div = 8'd3;
        issue(2'd1, LOAD, 16'd2, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            clk1();
            check("per_expire", expire[1], (k % 8 == 0) ? 1 : 0);
            check("per_active", active[1], 1);
        end

        // Pause and resume
        do_reset();
        issue(2'd2, LOAD, 16'd10, 1'b0);
        for (int k = 0; k < 4; k++) clk1();
        issue(2'd2, STOP, 16'd0, 1'b0);
        check("pause_active", active[2], 0);
        check("pause_rdata0", rdata, 6);
        for (int k = 0; k < 5; k++) begin
            clk1();
            check("pause_rdata", rdata, 6);
            check("pause_expire", expire[2], 0);
        end
        issue(2'd2, START, 16'd0, 1'b0);
        check("resume_active", active[2], 1);
        for (int k = 1; k <= 6; k++) begin
            clk1();
            check("resume_expire", expire[2], (k == 6) ? 1 : 0);
        end
        check("resume_done", active[2], 0);

        // LOAD wins over the expiring tick
        do_reset();
        issue(2'd3, LOAD, 16'd2, 1'b0);
        clk1();
        issue(2'd3, LOAD, 16'd5, 1'b0);
        check("coll_expire", expire[3], 0);
        check("coll_active", active[3], 1);
        clk1();
        check("coll_rdata", rdata, 5);
        check("coll_expire2", expire[3], 0);

        // LOAD 0 stops silently; START with count 0 does nothing
        issue(2'd3, LOAD, 16'd0, 1'b0);
        check("load0_active", active[3], 0);
        check("load0_expire", expire[3], 0);
        clk1();
        check("load0_rdata", rdata, 0);
        check("load0_expire2", expire[3], 0);
        issue(2'd3, START, 16'd0, 1'b0);
        check("start0_active", active[3], 0);
        clk1();
        check("start0_expire", expire[3], 0);

        // Out-of-range select on the 3-channel instance
        do_reset();
        issue(2'd3, LOAD, 16'd7, 1'b0);
        check("oor_active3", active3, 0);
        check("oor_main_active", active[3], 1);
        clk1();
        check("oor_rdata3", rdata3, 0);
        issue(2'd3, START, 16'd0, 1'b0);
        check("oor_start3", active3, 0);
        issue(2'd2, LOAD, 16'd5, 1'b0);
        check("inr_active3", active3, 3'b100);
        clk1();
        check("inr_rdata3", rdata3, 5);

        // Four channels loaded 1..4 on consecutive cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            cmd = LOAD;
            value = 16'(i + 1);
            periodic = 1'b0;
            clk1();
            check("ind_expire", expire, exp_ind[i]);
        end
        cmd = NOP;
        for (int k = 4; k < 10; k++) begin
            clk1();
            check("ind_expire", expire, exp_ind[k]);
        end
        check("ind_active", active, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
